// File: rtl/tdm_1_to_4_demux_pkg.sv
// Shared definitions for the TDM 4:1 link: FSM states, slot geometry and error limit.
// The transmit side imports the same package so both ends agree on framing.
package tdm_1_to_4_demux_pkg;

   typedef enum logic {
      ST_HUNT = 1'b0,
      ST_RECV = 1'b1
   } state_e;

   localparam int N_SLOTS = 4;
   localparam int SLOT_W  = 2;

   localparam logic [3:0] ERR_MAX = 4'hF;

endpackage

// File: rtl/hex_7seg_bitwise.sv
// Shared hex-to-seven-segment decoder, active-low segments ordered {g,f,e,d,c,b,a}.
module hex_7seg_bitwise (
   input  logic [3:0] value_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = 7'b1111111;
      case (value_i)
         4'h0: seg_o = 7'b1000000;
         4'h1: seg_o = 7'b1111001;
         4'h2: seg_o = 7'b0100100;
         4'h3: seg_o = 7'b0110000;
         4'h4: seg_o = 7'b0011001;
         4'h5: seg_o = 7'b0010010;
         4'h6: seg_o = 7'b0000010;
         4'h7: seg_o = 7'b1111000;
         4'h8: seg_o = 7'b0000000;
         4'h9: seg_o = 7'b0010000;
         4'hA: seg_o = 7'b0001000;
         4'hB: seg_o = 7'b0000011;
         4'hC: seg_o = 7'b1000110;
         4'hD: seg_o = 7'b0100001;
         4'hE: seg_o = 7'b0000110;
         default: seg_o = 7'b0001110;
      endcase
   end

endmodule

// File: rtl/tdm_tick_gen.sv
// Slot-rate tick generator: one-clock pulse every TICK_DIV cycles of CLOCK_50.
// Also used by the transmitter so both ends share the same slot timing.
module tdm_tick_gen #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic CLOCK_50,
   input  logic RESET_N,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick  = (cnt_q == CNT_LAST);
   assign cnt_d = tick ? '0 : cnt_q + 1'b1;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tdm_1_to_4_demux_top.sv
// Receive end of the 4:1 TDM bit path: rebuilds a 4-bit word from one serial bit plus a
// frame-sync marker, counting frames broken by an unexpected sync.
module tdm_1_to_4_demux_top
   import tdm_1_to_4_demux_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int SYNC_FF  = 2
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic [1:0] SW,
   output logic [7:0] LEDR,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1
);

   logic              tick;
   logic [1:0]        syncChain_q [SYNC_FF];
   logic              sd;
   logic              ss;
   state_e            state_q;
   logic [SLOT_W-1:0] slot_q;
   logic [N_SLOTS-1:0] staging_q;
   logic [N_SLOTS-1:0] word_q;
   logic [3:0]        errCnt_q;
   logic              frameValid_q;

   tdm_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .tick     (tick)
   );

   // Slide switches are asynchronous to CLOCK_50, so both bits pass a flop chain first.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < SYNC_FF; i++) begin
            syncChain_q[i] <= 2'b00;
         end
      end else begin
         syncChain_q[0] <= SW;
         for (int i = 1; i < SYNC_FF; i++) begin
            syncChain_q[i] <= syncChain_q[i-1];
         end
      end
   end

   assign sd = syncChain_q[SYNC_FF-1][0];
   assign ss = syncChain_q[SYNC_FF-1][1];

   // A sync in RECV always restarts the frame at slot 0; only a mid-frame one is an error.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q      <= ST_HUNT;
         slot_q       <= '0;
         staging_q    <= '0;
         word_q       <= '0;
         errCnt_q     <= '0;
         frameValid_q <= 1'b0;
      end else if (tick) begin
         frameValid_q <= 1'b0;
         case (state_q)
            ST_HUNT: begin
               if (ss) begin
                  staging_q <= {{(N_SLOTS-1){1'b0}}, sd};
                  slot_q    <= SLOT_W'(1);
                  state_q   <= ST_RECV;
               end
            end
            ST_RECV: begin
               if (ss) begin
                  if ((slot_q != '0) && (errCnt_q != ERR_MAX)) begin
                     errCnt_q <= errCnt_q + 4'd1;
                  end
                  staging_q <= {{(N_SLOTS-1){1'b0}}, sd};
                  slot_q    <= SLOT_W'(1);
               end else begin
                  staging_q[slot_q] <= sd;
                  slot_q            <= slot_q + 1'b1;
                  if (slot_q == SLOT_W'(N_SLOTS - 1)) begin
                     word_q       <= {sd, staging_q[N_SLOTS-2:0]};
                     frameValid_q <= 1'b1;
                     state_q      <= ST_HUNT;
                  end
               end
            end
            default: begin
               state_q <= ST_HUNT;
               slot_q  <= '0;
            end
         endcase
      end
   end

   assign LEDR = {frameValid_q, (state_q == ST_RECV), slot_q, word_q};

   hex_7seg_bitwise u_hex_word (
      .value_i (word_q),
      .seg_o   (HEX0)
   );

   hex_7seg_bitwise u_hex_err (
      .value_i (errCnt_q),
      .seg_o   (HEX1)
   );

endmodule
